vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised two-axis VGA timing generator, successor to the single-axis line timer. Chains a horizontal and a vertical phase counter and produces hsync, vsync, data-enable, pixel coordinates and frame/line strobes. Timing is runtime-reprogrammable, and a new set is applied only at a frame boundary. Sits between the pixel clock domain and the pixel/framebuffer pipeline.

## Interface
- H_WIDTH, 12: width of horizontal counters and x.
- V_WIDTH, 11: width of vertical counters and y.
- DEFAULT_MODE, VGA_640x480_60: vga_mode_e timing loaded at reset via vga_pkg::get_vga_timing.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  pixel enable; the block advances only when ce=1.
- cfg_valid  in  1  one-cycle strobe that latches h_cfg/v_cfg into the pending set.
- h_cfg  in  line_t  horizontal visible_area, front_porch, sync_pulse, back_porch, polarity.
- v_cfg  in  line_t  vertical timing, same fields (units are lines).
- cfg_applied  out  1  pulse on the ce cycle a pending set becomes active.
- hsync, vsync  out  1  sync outputs, polarity applied.
- de  out  1  high while both axes are in VISIBLE.
- x  out  H_WIDTH  horizontal visible index; 0 outside VISIBLE.
- y  out  V_WIDTH  vertical visible index; 0 outside VISIBLE.
- h_state, v_state  out  VGA_state_e  current phase per axis.
- sol, sof  out  1  start of line / start of frame (position x=0 or x=0,y=0).
- eol, eof  out  1  last pixel of line / last pixel of frame.

## Operation
- Each axis cycles VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE.
- The phase counter runs 0..len-1; the phase advances when counter = len-1.
- A phase with len=0 is skipped; the transition goes directly to the next non-zero phase.
- visible_area=0 on either axis is illegal. Such a set is rejected at apply time and the active set is kept.
- The vertical axis advances one step on each horizontal end-of-line (last BACK cycle, or the last cycle of the last non-zero phase).
- sync output = polarity while in SYNC, ~polarity otherwise. polarity=1 means an active-high pulse.
- Config handshake:
  - cfg_valid overwrites the pending set and sets a pending flag. A later cfg_valid before apply replaces it.
  - On the ce cycle where position wraps to (0,0), a pending set becomes active and the counters restart under the new timing.
  - cfg_applied=1 in the same cycle as the matching sof.
  - Without a pending set, timing is unchanged.
- Counter arithmetic is unsigned, at H_WIDTH/V_WIDTH bits. Configs with a total exceeding 2^WIDTH are illegal and give undefined behaviour.

## Timing
- All outputs are registered. They update only on clk edges with ce=1 and hold otherwise.
- Latency: outputs reflect the counter position of the preceding ce cycle (one ce of latency).
- Reset (asynchronous, immediate):
  - Counters go to position (0,0); h_state and v_state go to VISIBLE; the active set = DEFAULT_MODE; pending cleared.
  - hsync and vsync go to their inactive levels for DEFAULT_MODE.
  - de, x, y, sol, sof, eol, eof and cfg_applied go to 0.
- First ce after rst deasserts: de=1, x=0, y=0, sol=1, sof=1.
- sol/sof/eol/eof/cfg_applied are one ce cycle wide. At the last pixel of a frame, eol=eof=1 together.
- Simultaneous cfg_valid and frame wrap: the previous pending set, if any, is applied. The new set stays pending for the next frame.
- Reset mid-line or mid-frame discards pending config and restarts at (0,0) under DEFAULT_MODE.

## Structure
- vga_pkg holds line_t, VGA_state_e, vga_mode_e and get_vga_timing. Add a next_state function for phase order and zero-length skipping.
- Sub-module vga_phase_counter, instantiated twice (H and V):
  - Inputs: step, line_t config, restart.
  - Outputs: state, phase counter, visible index, sync and a wrap pulse.
- The top level handles the chaining, the pending/active config registers and strobe generation.

## Test plan
- 640x480@60 (h 640/16/96/48, v 480/10/2/33, polarity 0), ce=1 -> 800-clk line; hsync low at h positions 656..751; de high at x 0..639; sof first ce after reset.
- Same mode -> vsync low for lines 490..491 (1600 clks); frame period 420000 clks; eof coincides with eol at (799,524).
- ce toggling 1/0 -> outputs change only on ce cycles; line length 1600 clk; no strobe longer than one ce.
- Mid-frame cfg_valid with h 8/2/3/1, v 4/1/1/1, polarity 1 -> current frame completes unchanged; cfg_applied with the next sof; new line 14 ce, frame 98 ce, hsync high at positions 10..12.
- h front_porch=0 -> FRONT never entered; SYNC begins at x position = visible_area; line length reduced by 16.
- rst pulse mid-line while a cfg is pending -> outputs go inactive immediately; after release, restart at (0,0) in DEFAULT_MODE; the pending cfg is never applied.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, preset modes and phase-ordering helpers for the VGA timing generator.
package vga_pkg;

  localparam int CFG_W = 12;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } VGA_state_e;

  typedef enum logic [1:0] {
    VGA_640x480_60  = 2'd0,
    VGA_800x600_60  = 2'd1,
    VGA_1024x768_60 = 2'd2,
    VGA_SIM_TINY    = 2'd3
  } vga_mode_e;

  typedef struct packed {
    logic [CFG_W-1:0] visible_area;
    logic [CFG_W-1:0] front_porch;
    logic [CFG_W-1:0] sync_pulse;
    logic [CFG_W-1:0] back_porch;
    logic             polarity;
  } line_t;

  typedef struct packed {
    line_t h;
    line_t v;
  } vga_timing_t;

  function automatic line_t mk_line(input logic [CFG_W-1:0] vis,
                                    input logic [CFG_W-1:0] fp,
                                    input logic [CFG_W-1:0] sp,
                                    input logic [CFG_W-1:0] bp,
                                    input logic             pol);
    line_t l;
    l.visible_area = vis;
    l.front_porch  = fp;
    l.sync_pulse   = sp;
    l.back_porch   = bp;
    l.polarity     = pol;
    return l;
  endfunction

  function automatic vga_timing_t get_vga_timing(input vga_mode_e mode);
    vga_timing_t t;
    case (mode)
      VGA_800x600_60: begin
        t.h = mk_line(12'd800, 12'd40, 12'd128, 12'd88, 1'b1);
        t.v = mk_line(12'd600, 12'd1, 12'd4, 12'd23, 1'b1);
      end
      VGA_1024x768_60: begin
        t.h = mk_line(12'd1024, 12'd24, 12'd136, 12'd160, 1'b0);
        t.v = mk_line(12'd768, 12'd3, 12'd6, 12'd29, 1'b0);
      end
      // Deliberately tiny raster for fast simulation of whole frames.
      VGA_SIM_TINY: begin
        t.h = mk_line(12'd4, 12'd1, 12'd2, 12'd1, 1'b0);
        t.v = mk_line(12'd3, 12'd1, 12'd1, 12'd1, 1'b0);
      end
      default: begin
        t.h = mk_line(12'd640, 12'd16, 12'd96, 12'd48, 1'b0);
        t.v = mk_line(12'd480, 12'd10, 12'd2, 12'd33, 1'b0);
      end
    endcase
    return t;
  endfunction

  function automatic logic [CFG_W-1:0] phase_len(input VGA_state_e s, input line_t cfg);
    logic [CFG_W-1:0] len;
    case (s)
      FRONT:   len = cfg.front_porch;
      SYNC:    len = cfg.sync_pulse;
      BACK:    len = cfg.back_porch;
      default: len = cfg.visible_area;
    endcase
    return len;
  endfunction

  function automatic VGA_state_e succ_state(input VGA_state_e s);
    VGA_state_e n;
    case (s)
      VISIBLE: n = FRONT;
      FRONT:   n = SYNC;
      SYNC:    n = BACK;
      default: n = VISIBLE;
    endcase
    return n;
  endfunction

  // Walks the phase ring until a non-empty phase is found; VISIBLE is the fallback.
  function automatic VGA_state_e next_state(input VGA_state_e s, input line_t cfg);
    VGA_state_e n;
    VGA_state_e r;
    logic       found;
    n     = s;
    r     = VISIBLE;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = succ_state(n);
      if (!found && phase_len(n, cfg) != '0) begin
        r     = n;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic timing_legal(input vga_timing_t t);
    return (t.h.visible_area != '0) && (t.v.visible_area != '0);
  endfunction

endpackage

// File: rtl/vga_timing_gen_phase_counter.sv
// One axis of the raster: phase state plus in-phase counter, with end-of-axis detection.
module vga_phase_counter
  import vga_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         restart,
  input  line_t        cfg,
  output VGA_state_e   state,
  output logic [W-1:0] cnt,
  output logic [W-1:0] idx,
  output logic         sync,
  output logic         last,
  output logic         wrap
);

  VGA_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] len_w;
  logic         phase_end;
  VGA_state_e   nxt;

  always_comb begin
    len_w     = W'(phase_len(state_q, cfg));
    nxt       = next_state(state_q, cfg);
    phase_end = (cnt_q == len_w - W'(1));
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (step) begin
      if (restart) begin
        state_d = VISIBLE;
        cnt_d   = '0;
      end else if (phase_end) begin
        state_d = nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VISIBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The axis ends on the last cycle of whichever phase hands back to VISIBLE.
  assign last  = phase_end && (nxt == VISIBLE);
  assign wrap  = step && last;
  assign state = state_q;
  assign cnt   = cnt_q;
  assign idx   = (state_q == VISIBLE) ? cnt_q : '0;
  assign sync  = (state_q == SYNC) ? cfg.polarity : ~cfg.polarity;

endmodule

// File: rtl/vga_timing_gen.sv
// Two-axis VGA timing generator with frame-boundary reprogramming of the raster timing.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int        H_WIDTH      = 12,
  parameter int        V_WIDTH      = 11,
  parameter vga_mode_e DEFAULT_MODE = VGA_640x480_60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               cfg_valid,
  input  line_t              h_cfg,
  input  line_t              v_cfg,
  output logic               cfg_applied,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [H_WIDTH-1:0] x,
  output logic [V_WIDTH-1:0] y,
  output VGA_state_e         h_state,
  output VGA_state_e         v_state,
  output logic               sol,
  output logic               sof,
  output logic               eol,
  output logic               eof
);

  localparam vga_timing_t DEF_TIMING = get_vga_timing(DEFAULT_MODE);

  vga_timing_t active_q, active_d;
  vga_timing_t pending_q, pending_d;
  logic        pending_valid_q, pending_valid_d;
  logic        just_applied_q, just_applied_d;

  logic               cfg_applied_q, cfg_applied_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [H_WIDTH-1:0] x_q, x_d;
  logic [V_WIDTH-1:0] y_q, y_d;
  VGA_state_e         h_state_q, h_state_d;
  VGA_state_e         v_state_q, v_state_d;
  logic               sol_q, sol_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;

  VGA_state_e         h_st, v_st;
  logic [H_WIDTH-1:0] h_cnt, h_idx;
  logic [V_WIDTH-1:0] v_cnt, v_idx;
  logic               h_sync, v_sync;
  logic               h_last, v_last;
  logic               h_wrap, frame_wrap;
  logic               apply;

  assign apply = frame_wrap && pending_valid_q && timing_legal(pending_q);

  vga_phase_counter #(.W(H_WIDTH)) u_h (
    .clk     (clk),
    .rst     (rst),
    .step    (ce),
    .restart (apply),
    .cfg     (active_q.h),
    .state   (h_st),
    .cnt     (h_cnt),
    .idx     (h_idx),
    .sync    (h_sync),
    .last    (h_last),
    .wrap    (h_wrap)
  );

  // Vertical axis advances once per completed line.
  vga_phase_counter #(.W(V_WIDTH)) u_v (
    .clk     (clk),
    .rst     (rst),
    .step    (h_wrap),
    .restart (apply),
    .cfg     (active_q.v),
    .state   (v_st),
    .cnt     (v_cnt),
    .idx     (v_idx),
    .sync    (v_sync),
    .last    (v_last),
    .wrap    (frame_wrap)
  );

  always_comb begin
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    just_applied_d  = just_applied_q;
    cfg_applied_d   = cfg_applied_q;
    hsync_d         = hsync_q;
    vsync_d         = vsync_q;
    de_d            = de_q;
    x_d             = x_q;
    y_d             = y_q;
    h_state_d       = h_state_q;
    v_state_d       = v_state_q;
    sol_d           = sol_q;
    sof_d           = sof_q;
    eol_d           = eol_q;
    eof_d           = eof_q;

    // An illegal pending set is consumed at the boundary but never activated.
    if (frame_wrap && pending_valid_q) begin
      pending_valid_d = 1'b0;
      if (apply) begin
        active_d = pending_q;
      end
    end
    // Evaluated after the apply so a set arriving on the wrap waits a frame.
    if (cfg_valid) begin
      pending_d.h     = h_cfg;
      pending_d.v     = v_cfg;
      pending_valid_d = 1'b1;
    end

    if (ce) begin
      just_applied_d = apply;
      cfg_applied_d  = just_applied_q;
      hsync_d        = h_sync;
      vsync_d        = v_sync;
      de_d           = (h_st == VISIBLE) && (v_st == VISIBLE);
      x_d            = h_idx;
      y_d            = v_idx;
      h_state_d      = h_st;
      v_state_d      = v_st;
      sol_d          = (h_st == VISIBLE) && (h_cnt == '0);
      sof_d          = (h_st == VISIBLE) && (h_cnt == '0) && (v_st == VISIBLE) && (v_cnt == '0);
      eol_d          = h_last;
      eof_d          = h_last && v_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q        <= DEF_TIMING;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      just_applied_q  <= 1'b0;
      cfg_applied_q   <= 1'b0;
      hsync_q         <= ~DEF_TIMING.h.polarity;
      vsync_q         <= ~DEF_TIMING.v.polarity;
      de_q            <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      h_state_q       <= VISIBLE;
      v_state_q       <= VISIBLE;
      sol_q           <= 1'b0;
      sof_q           <= 1'b0;
      eol_q           <= 1'b0;
      eof_q           <= 1'b0;
    end else begin
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      just_applied_q  <= just_applied_d;
      cfg_applied_q   <= cfg_applied_d;
      hsync_q         <= hsync_d;
      vsync_q         <= vsync_d;
      de_q            <= de_d;
      x_q             <= x_d;
      y_q             <= y_d;
      h_state_q       <= h_state_d;
      v_state_q       <= v_state_d;
      sol_q           <= sol_d;
      sof_q           <= sof_d;
      eol_q           <= eol_d;
      eof_q           <= eof_d;
    end
  end

  assign cfg_applied = cfg_applied_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign h_state     = h_state_q;
  assign v_state     = v_state_q;
  assign sol         = sol_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign eof         = eof_q;

endmodule
